// File: rtl/qmult_pipe.sv
// qmult_pipe: three-stage pipelined signed fixed-point multiplier.
//
// Operands and result are signed two's complement numbers with FP_WIDTH
// fractional bits. S1 registers the operands. S2 registers the full
// 2*DATA_WIDTH product. S3 registers the rounded, shifted and
// saturated/wrapped result together with its overflow flag.
// A single global stall freezes all three stages whenever the output
// holds a result that has not been taken.
//
// Parameters:
//   DATA_WIDTH - operand/result width (8..64)
//   FP_WIDTH   - fractional bits (1..DATA_WIDTH-1)
//   ROUND      - 1: round half toward +inf, 0: truncate toward -inf
//   SATURATE   - 1: clamp on overflow, 0: keep low DATA_WIDTH bits
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   s_valid  - operands valid
//   s_ready  - block accepts operands this cycle
//   s_a, s_b - signed operands
//   m_valid  - result valid
//   m_ready  - downstream accepts result
//   m_result - signed product in the operand Q format
//   m_ovf    - result overflowed its range (qualified by m_valid)
module qmult_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FP_WIDTH   = 24,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a,
  input  logic [DATA_WIDTH-1:0] s_b,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_result,
  output logic                  m_ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  // Half an LSB of the result, added before the shift when rounding.
  // The sum is one bit wider than the product, so it can never wrap.
  localparam logic [PW:0] RND_C =
    (ROUND != 0) ? ((PW+1)'(1) << (FP_WIDTH - 1)) : '0;

  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  advance;
  logic                  v1_q, v2_q, v3_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]         prod_d, prod_q;
  logic [PW:0]           sum_d, shr_d;
  logic                  ovf_d, ovf_q;
  logic [DATA_WIDTH-1:0] res_d, res_q;

  // Every stage moves whenever the output slot is empty or being drained.
  // During reset v3_q is 0, so s_ready reads 1 while nothing is captured.
  always_comb begin
    advance  = !v3_q || m_ready;
    s_ready  = advance;
    m_valid  = v3_q;
    m_result = res_q;
    m_ovf    = ovf_q;
  end

  // Valid bits follow the data on every advance, so bubbles travel through
  // the pipe and the data registers themselves need no reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= s_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Operand and product registers.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      a_q    <= s_a;
      b_q    <= s_b;
      prod_q <= prod_d;
    end
  end

  // Sign-extending both operands to the full product width makes the low
  // PW bits of an ordinary multiply equal to the signed product.
  always_comb begin
    prod_d = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q} *
             {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q};
  end

  // Round, shift, then detect overflow: the shifted value fits only when all
  // bits from the result sign bit upward are identical.
  always_comb begin
    sum_d = {prod_q[PW-1], prod_q} + RND_C;
    shr_d = $signed(sum_d) >>> FP_WIDTH;
    ovf_d = !((&shr_d[PW:DATA_WIDTH-1]) || !(|shr_d[PW:DATA_WIDTH-1]));
    res_d = shr_d[DATA_WIDTH-1:0];
    if ((SATURATE != 0) && ovf_d) begin
      res_d = shr_d[PW] ? MIN_NEG : MAX_POS;
    end
  end

  // Output stage; reset so m_result and m_ovf read 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
